// File: rtl/dec_n_scan_pol_ctrl.sv
// N-to-2**N decoder with direct-select and automatic dwell-timed scan modes.
// Registered outputs are inverted globally by pol and per bit by pol_mask.
module dec_n_scan_pol_ctrl #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic                pol,
  input  logic [(2**N)-1:0]   pol_mask,
  output logic [(2**N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int M  = 2 ** N;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST   = N'(M - 1);

  typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            wrap_q, wrap_d;
  logic [M-1:0]    y_q, y_d;
  logic [M-1:0]    dec;

  always_comb begin
    if (!en) begin
      state_d = ST_OFF;
    end else if (mode) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_DIRECT;
    end

    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    dec     = '0;

    case (state_d)
      ST_DIRECT: begin
        idx_d   = sel;
        dwell_d = '0;
      end
      ST_SCAN: begin
        // Entering scan always restarts from sel with a fresh dwell.
        if (state_q != ST_SCAN) begin
          idx_d   = sel;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          idx_d   = idx_q + N'(1);
          wrap_d  = (idx_q == IDX_LAST);
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: begin
      end
    endcase

    if (state_d != ST_OFF) begin
      dec[idx_d] = 1'b1;
    end
    y_d = dec ^ {M{pol}} ^ pol_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_n_scan_pol_ctrl.sv
// Directed bench for dec_n_scan_pol_ctrl: one DWELL=3 instance and one DWELL=1 instance, N=2.
module tb_dec_n_scan_pol_ctrl;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       mode;
  logic [1:0] sel;
  logic       pol;
  logic [3:0] pol_mask;
  logic [3:0] y;
  logic [1:0] idx;
  logic       wrap;
  logic [3:0] y1;
  logic [1:0] idx1;
  logic       wrap1;

  int tests_run    = 0;
  int tests_failed = 0;

  dec_n_scan_pol_ctrl #(.N(2), .DWELL(3)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel),
    .pol(pol), .pol_mask(pol_mask), .y(y), .idx(idx), .wrap(wrap)
  );

  dec_n_scan_pol_ctrl #(.N(2), .DWELL(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel),
    .pol(pol), .pol_mask(pol_mask), .y(y1), .idx(idx1), .wrap(wrap1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b1;
    en       = 1'b0;
    mode     = 1'b0;
    sel      = 2'd0;
    pol      = 1'b1;
    pol_mask = 4'b1111;
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: y=%b idx=%0d wrap=%b, want 0000/0/0", y, idx, wrap);
    end
    step();
    step();
    tests_run++;
    if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0 || y1 !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: y=%b idx=%0d wrap=%b y1=%b, want 0000/0/0/0000", y, idx, wrap, y1);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0; pol = 1'b0; pol_mask = 4'b0000; sel = 2'd2;
    step();
    tests_run++;
    if (y !== 4'b0100 || idx !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL direct_sel2: y=%b idx=%0d, want 0100/2", y, idx);
    end
    pol = 1'b1;
    step();
    tests_run++;
    if (y !== 4'b1011 || idx !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL direct_pol: y=%b idx=%0d, want 1011/2", y, idx);
    end
  endtask

  task automatic test_mask();
    sel = 2'd1; pol = 1'b1; pol_mask = 4'b0001;
    step();
    tests_run++;
    if (y !== 4'b1100 || idx !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL mask: y=%b idx=%0d, want 1100/1", y, idx);
    end
  endtask

  task automatic test_scan();
    logic [1:0] exp_idx  [7] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       exp_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_y;
    pol = 1'b0; pol_mask = 4'b0000; mode = 1'b1; sel = 2'd3;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) sel = 2'd1;
      exp_y = 4'b0001 << exp_idx[i];
      tests_run++;
      if (idx !== exp_idx[i] || wrap !== exp_wrap[i] || y !== exp_y) begin
        tests_failed++;
        $display("[TB] FAIL scan[%0d]: idx=%0d wrap=%b y=%b, want %0d/%b/%b",
                 i, idx, wrap, y, exp_idx[i], exp_wrap[i], exp_y);
      end
    end
  endtask

  task automatic test_enable();
    logic [1:0] exp_idx [4] = '{2'd2, 2'd2, 2'd2, 2'd3};
    step();
    en = 1'b0; pol = 1'b1;
    step();
    tests_run++;
    if (y !== 4'b1111 || idx !== 2'd1 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL off_pol1: y=%b idx=%0d wrap=%b, want 1111/1/0", y, idx, wrap);
    end
    pol = 1'b0;
    step();
    tests_run++;
    if (y !== 4'b0000 || idx !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL off_pol0: y=%b idx=%0d, want 0000/1", y, idx);
    end
    en = 1'b1; sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (idx !== exp_idx[i] || wrap !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reenter[%0d]: idx=%0d wrap=%b, want %0d/0", i, idx, wrap, exp_idx[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    pol = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    tests_run++;
    if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: y=%b idx=%0d wrap=%b, want 0000/0/0", y, idx, wrap);
    end
    #2 reset_n = 1'b1;
    step();
    tests_run++;
    if (y !== 4'b1011 || idx !== 2'd2 || wrap !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_entry: y=%b idx=%0d wrap=%b, want 1011/2/0", y, idx, wrap);
    end
  endtask

  task automatic test_dwell1();
    logic [1:0] exp_idx  [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_wrap [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_y;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    en = 1'b1; mode = 1'b1; sel = 2'd0; pol = 1'b0; pol_mask = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      step();
      exp_y = 4'b0001 << exp_idx[i];
      tests_run++;
      if (idx1 !== exp_idx[i] || wrap1 !== exp_wrap[i] || y1 !== exp_y) begin
        tests_failed++;
        $display("[TB] FAIL dwell1[%0d]: idx=%0d wrap=%b y=%b, want %0d/%b/%b",
                 i, idx1, wrap1, y1, exp_idx[i], exp_wrap[i], exp_y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_mask();
    test_scan();
    test_enable();
    test_async_reset();
    test_dwell1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
